// File: rtl/tinyml_display_pkg.sv
// Constants and types shared by the DSI display stage and its overlay stages.
// A video beat carries two pixels per clock, 8 bits per channel per pixel.
package tinyml_display_pkg;

   localparam int DSI_H_ACTIVE = 1080;
   localparam int DSI_V_ACTIVE = 1920;
   localparam int PIX_W        = 8;
   localparam int PPC          = 2;
   localparam int CH_W         = PIX_W * PPC;
   localparam int RGB_W        = 3 * PIX_W;

   typedef struct packed {
      logic            hs;
      logic            vs;
      logic            valid;
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] b;
   } video_t;

endpackage

// File: rtl/tinyml_display_box_hit.sv
// Combinational test of whether one pixel lies on the border of the box
// outline. Widened arithmetic keeps x0+t from overflowing and lets x1-t go negative.
module tinyml_display_box_hit #(
   parameter int COORD_W = 11
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   input  logic [3:0]         thick,
   input  logic               box_en,
   output logic               hit
);

   localparam int W = COORD_W + 1;

   logic [W-1:0] t_w;
   logic [W-1:0] ix0, iy0, ix1, iy1;
   logic         x_under, y_under;
   logic         outer, inner;

   assign t_w = W'(thick);
   assign ix0 = {1'b0, x0} + t_w;
   assign iy0 = {1'b0, y0} + t_w;
   assign ix1 = {1'b0, x1} - t_w;
   assign iy1 = {1'b0, y1} - t_w;

   // An inner edge pushed below zero leaves no inner rectangle at all.
   assign x_under = {1'b0, x1} < t_w;
   assign y_under = {1'b0, y1} < t_w;

   assign outer = (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
   assign inner = !x_under && !y_under &&
                  ({1'b0, x} >= ix0) && ({1'b0, x} <= ix1) &&
                  ({1'b0, y} >= iy0) && ({1'b0, y} <= iy1);

   assign hit = box_en && (thick != 4'd0) && outer && !inner;

endmodule

// File: rtl/tinyml_display_box_overlay.sv
// Draws one bounding-box outline over the 2-pixel-per-clock display stream.
// Two register stages: per-lane hit flags, then the colour mux.
module tinyml_display_box_overlay
   import tinyml_display_pkg::*;
#(
   parameter int H_ACTIVE = DSI_H_ACTIVE,
   parameter int V_ACTIVE = DSI_V_ACTIVE,
   parameter int COORD_W  = 11
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_hs,
   input  logic               in_vs,
   input  logic               in_valid,
   input  logic [15:0]        in_r,
   input  logic [15:0]        in_g,
   input  logic [15:0]        in_b,
   input  logic               cfg_box_en,
   input  logic [COORD_W-1:0] cfg_x0,
   input  logic [COORD_W-1:0] cfg_y0,
   input  logic [COORD_W-1:0] cfg_x1,
   input  logic [COORD_W-1:0] cfg_y1,
   input  logic [3:0]         cfg_thick,
   input  logic [23:0]        cfg_colour,
   output logic               out_hs,
   output logic               out_vs,
   output logic               out_valid,
   output logic [15:0]        out_r,
   output logic [15:0]        out_g,
   output logic [15:0]        out_b,
   output logic               frame_done
);

   localparam int XP_W = COORD_W - 1;
   localparam logic [XP_W-1:0]    X_LAST = XP_W'(H_ACTIVE / 2 - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

   logic               vs_prev_q, vs_prev_d;
   logic               hs_prev_q, hs_prev_d;
   logic               valid_prev_q, valid_prev_d;
   logic [XP_W-1:0]    x_pair_q, x_pair_d;
   logic [COORD_W-1:0] y_line_q, y_line_d;

   logic               sh_en_q, sh_en_d;
   logic [COORD_W-1:0] sh_x0_q, sh_x0_d, sh_y0_q, sh_y0_d;
   logic [COORD_W-1:0] sh_x1_q, sh_x1_d, sh_y1_q, sh_y1_d;
   logic [3:0]         sh_thick_q, sh_thick_d;
   logic [RGB_W-1:0]   sh_colour_q, sh_colour_d;

   video_t             s1_q, s1_d;
   logic [PPC-1:0]     hit_q, hit_d;
   logic [RGB_W-1:0]   colour_s1_q, colour_s1_d;
   logic               last_s1_q, last_s1_d;
   video_t             out_q, out_d;
   logic               frame_done_q, frame_done_d;

   logic               vs_rise, hs_rise, valid_fall;
   logic [XP_W-1:0]    cur_x;
   logic [COORD_W-1:0] cur_y;
   logic [PPC-1:0]     lane_hit;

   // Edge detection, pixel coordinates, counters and the per-frame shadow.
   always_comb begin
      // NOTE: every output of a combinational block gets a value on every path
      // (defaults first), otherwise synthesis infers a latch.
      vs_rise    = in_vs & ~vs_prev_q;
      hs_rise    = in_hs & ~hs_prev_q;
      valid_fall = valid_prev_q & ~in_valid;

      // A vs rise on a valid cycle places that pixel at the frame origin.
      cur_x = (vs_rise || hs_rise) ? '0 : x_pair_q;
      cur_y = vs_rise ? '0 : y_line_q;

      sh_en_d     = sh_en_q;
      sh_x0_d     = sh_x0_q;
      sh_y0_d     = sh_y0_q;
      sh_x1_d     = sh_x1_q;
      sh_y1_d     = sh_y1_q;
      sh_thick_d  = sh_thick_q;
      sh_colour_d = sh_colour_q;
      if (vs_rise) begin
         sh_en_d     = cfg_box_en;
         sh_x0_d     = cfg_x0;
         sh_y0_d     = cfg_y0;
         sh_x1_d     = cfg_x1;
         sh_y1_d     = cfg_y1;
         sh_thick_d  = cfg_thick;
         sh_colour_d = cfg_colour;
      end

      x_pair_d = cur_x;
      if (in_valid && cur_x != X_LAST) x_pair_d = cur_x + XP_W'(1);
      y_line_d = cur_y;
      if (valid_fall && !vs_rise && cur_y != Y_LAST) y_line_d = cur_y + COORD_W'(1);

      vs_prev_d    = in_vs;
      hs_prev_d    = in_hs;
      valid_prev_d = in_valid;
   end

   tinyml_display_box_hit #(.COORD_W(COORD_W)) u_hit_lane0 (
      .x      ({cur_x, 1'b0}),
      .y      (cur_y),
      .x0     (sh_x0_d),
      .y0     (sh_y0_d),
      .x1     (sh_x1_d),
      .y1     (sh_y1_d),
      .thick  (sh_thick_d),
      .box_en (sh_en_d),
      .hit    (lane_hit[0])
   );

   tinyml_display_box_hit #(.COORD_W(COORD_W)) u_hit_lane1 (
      .x      ({cur_x, 1'b1}),
      .y      (cur_y),
      .x0     (sh_x0_d),
      .y0     (sh_y0_d),
      .x1     (sh_x1_d),
      .y1     (sh_y1_d),
      .thick  (sh_thick_d),
      .box_en (sh_en_d),
      .hit    (lane_hit[1])
   );

   // Pipeline: stage 1 holds the beat and its hit flags, stage 2 the overlaid beat.
   always_comb begin
      s1_d        = '{hs: in_hs, vs: in_vs, valid: in_valid, r: in_r, g: in_g, b: in_b};
      hit_d       = lane_hit & {PPC{in_valid}};
      colour_s1_d = sh_colour_d;
      last_s1_d   = in_valid && (cur_x == X_LAST) && (cur_y == Y_LAST);

      out_d = s1_q;
      for (int l = 0; l < PPC; l++) begin
         if (hit_q[l]) begin
            out_d.r[l*PIX_W +: PIX_W] = colour_s1_q[0       +: PIX_W];
            out_d.g[l*PIX_W +: PIX_W] = colour_s1_q[PIX_W   +: PIX_W];
            out_d.b[l*PIX_W +: PIX_W] = colour_s1_q[2*PIX_W +: PIX_W];
         end
      end
      frame_done_d = last_s1_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_prev_q    <= 1'b0;
         hs_prev_q    <= 1'b0;
         valid_prev_q <= 1'b0;
         x_pair_q     <= '0;
         y_line_q     <= '0;
         sh_en_q      <= 1'b0;
         sh_x0_q      <= '0;
         sh_y0_q      <= '0;
         sh_x1_q      <= '0;
         sh_y1_q      <= '0;
         sh_thick_q   <= '0;
         sh_colour_q  <= '0;
         s1_q         <= '0;
         hit_q        <= '0;
         colour_s1_q  <= '0;
         last_s1_q    <= 1'b0;
         out_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         vs_prev_q    <= vs_prev_d;
         hs_prev_q    <= hs_prev_d;
         valid_prev_q <= valid_prev_d;
         x_pair_q     <= x_pair_d;
         y_line_q     <= y_line_d;
         sh_en_q      <= sh_en_d;
         sh_x0_q      <= sh_x0_d;
         sh_y0_q      <= sh_y0_d;
         sh_x1_q      <= sh_x1_d;
         sh_y1_q      <= sh_y1_d;
         sh_thick_q   <= sh_thick_d;
         sh_colour_q  <= sh_colour_d;
         s1_q         <= s1_d;
         hit_q        <= hit_d;
         colour_s1_q  <= colour_s1_d;
         last_s1_q    <= last_s1_d;
         out_q        <= out_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign out_hs     = out_q.hs;
   assign out_vs     = out_q.vs;
   assign out_valid  = out_q.valid;
   assign out_r      = out_q.r;
   assign out_g      = out_q.g;
   assign out_b      = out_q.b;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tinyml_display_box_overlay.sv
// Bench for the box overlay: a reference model predicts every output beat two
// cycles ahead, and a table of single-pixel probes pins literal expectations.
module tb_tinyml_display_box_overlay;

   localparam int H  = 1080;
   localparam int V  = 1920;
   localparam int CW = 11;
   localparam logic [23:0] GREEN = 24'h00FF00;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_hs, in_vs, in_valid;
   logic [15:0]   in_r, in_g, in_b;
   logic          cfg_box_en;
   logic [CW-1:0] cfg_x0, cfg_y0, cfg_x1, cfg_y1;
   logic [3:0]    cfg_thick;
   logic [23:0]   cfg_colour;
   logic          out_hs, out_vs, out_valid;
   logic [15:0]   out_r, out_g, out_b;
   logic          frame_done;

   always #5 clk = ~clk;

   tinyml_display_box_overlay #(.H_ACTIVE(H), .V_ACTIVE(V), .COORD_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_hs      (in_hs),
      .in_vs      (in_vs),
      .in_valid   (in_valid),
      .in_r       (in_r),
      .in_g       (in_g),
      .in_b       (in_b),
      .cfg_box_en (cfg_box_en),
      .cfg_x0     (cfg_x0),
      .cfg_y0     (cfg_y0),
      .cfg_x1     (cfg_x1),
      .cfg_y1     (cfg_y1),
      .cfg_thick  (cfg_thick),
      .cfg_colour (cfg_colour),
      .out_hs     (out_hs),
      .out_vs     (out_vs),
      .out_valid  (out_valid),
      .out_r      (out_r),
      .out_g      (out_g),
      .out_b      (out_b),
      .frame_done (frame_done)
   );

   typedef struct {
      logic [51:0] vec;
      bit          probe;
      int          lane;
      logic [7:0]  pexp;
   } exp_t;

   typedef struct {
      bit en;
      int x0, y0, x1, y1, t;
      int px, py;
      bit exp_col;
   } vec_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   fd_count = 0;
   int   probe_cnt = 0;

   // Reference model state: shadow config, counters, previous syncs.
   bit          m_en;
   int          m_x0, m_y0, m_x1, m_y1, m_t;
   logic [23:0] m_col;
   int          mx, my;
   bit          m_vs_p, m_hs_p, m_val_p;

   int          pr_pair = -1, pr_lane = 0, pr_y = -1;
   bit          pr_exp;
   logic [7:0]  pr_col;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic bit model_hit(input int x, input int y);
      bit outer, inner;
      if (!m_en || m_t == 0) return 1'b0;
      outer = (x >= m_x0) && (x <= m_x1) && (y >= m_y0) && (y <= m_y1);
      inner = (x >= m_x0 + m_t) && (x <= m_x1 - m_t) &&
              (y >= m_y0 + m_t) && (y <= m_y1 - m_t);
      return outer && !inner;
   endfunction

   task automatic model_reset();
      m_en = 0; m_x0 = 0; m_y0 = 0; m_x1 = 0; m_y1 = 0; m_t = 0; m_col = '0;
      mx = 0; my = 0; m_vs_p = 0; m_hs_p = 0; m_val_p = 0;
   endtask

   // One beat per call; every post-reset cycle goes through here so the
   // scoreboard stays exactly two entries ahead of the DUT output.
   task automatic drive(input bit hs, input bit vs, input bit valid, input bit rel = 1'b0);
      exp_t        e;
      logic [15:0] r, g, b, er, eg, eb;
      bit          vr, hr, vf, fd;
      int          cx, cy;
      @(negedge clk);
      if (rel) rst_n = 1'b1;
      r = 16'($urandom); g = 16'($urandom); b = 16'($urandom);
      in_hs = hs; in_vs = vs; in_valid = valid; in_r = r; in_g = g; in_b = b;
      if (!rst_n) return;
      vr = vs && !m_vs_p;
      hr = hs && !m_hs_p;
      vf = m_val_p && !valid;
      if (vr) begin
         m_en = cfg_box_en; m_x0 = int'(cfg_x0); m_y0 = int'(cfg_y0);
         m_x1 = int'(cfg_x1); m_y1 = int'(cfg_y1); m_t = int'(cfg_thick); m_col = cfg_colour;
      end
      cx = (vr || hr) ? 0 : mx;
      cy = vr ? 0 : my;
      er = r; eg = g; eb = b;
      for (int l = 0; l < 2; l++) begin
         if (valid && model_hit(2 * cx + l, cy)) begin
            er[l*8 +: 8] = m_col[7:0];
            eg[l*8 +: 8] = m_col[15:8];
            eb[l*8 +: 8] = m_col[23:16];
         end
      end
      fd      = valid && (cx == H / 2 - 1) && (cy == V - 1);
      e.vec   = {hs, vs, valid, er, eg, eb, fd};
      e.probe = valid && (cx == pr_pair) && (cy == pr_y);
      e.lane  = pr_lane;
      e.pexp  = pr_exp ? pr_col : g[pr_lane*8 +: 8];
      sb.push_back(e);
      mx = valid ? ((cx < H / 2 - 1) ? cx + 1 : cx) : cx;
      my = (vf && !vr && cy < V - 1) ? cy + 1 : cy;
      m_vs_p = vs; m_hs_p = hs; m_val_p = valid;
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rst_n && sb.size() >= 2) begin
         e = sb.pop_front();
         check("pipe", 64'({out_hs, out_vs, out_valid, out_r, out_g, out_b, frame_done}), 64'(e.vec));
         if (e.probe) begin
            probe_cnt++;
            check("point", 64'(out_g[e.lane*8 +: 8]), 64'(e.pexp));
         end
      end
      if (rst_n && frame_done) fd_count++;
   end

   task automatic set_cfg(input bit en, input int x0, input int y0, input int x1, input int y1,
                          input int t, input logic [23:0] col);
      cfg_box_en = en;
      cfg_x0 = CW'(x0); cfg_y0 = CW'(y0); cfg_x1 = CW'(x1); cfg_y1 = CW'(y1);
      cfg_thick = 4'(t); cfg_colour = col;
   endtask

   task automatic set_probe(input int px, input int py, input bit exp_col);
      pr_pair = px / 2; pr_lane = px % 2; pr_y = py; pr_exp = exp_col; pr_col = cfg_colour[15:8];
   endtask

   task automatic vs_pulse();
      drive(0, 1, 0);
      drive(0, 0, 0);
   endtask

   task automatic line(input int npairs);
      drive(1, 0, 0);
      repeat (npairs) drive(0, 0, 1);
      drive(0, 0, 0);
   endtask

   task automatic outputs_zero(input string name);
      check(name, 64'({out_hs, out_vs, out_valid, out_r, out_g, out_b, frame_done}), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[19];
      int   p0;
      tbl[0]  = '{1, 100, 200, 299, 399, 2, 100, 200, 1};
      tbl[1]  = '{1, 100, 200, 299, 399, 2, 101, 300, 1};
      tbl[2]  = '{1, 100, 200, 299, 399, 2, 299, 399, 1};
      tbl[3]  = '{1, 100, 200, 299, 399, 2, 150, 201, 1};
      tbl[4]  = '{1, 100, 200, 299, 399, 2, 102, 300, 0};
      tbl[5]  = '{1, 100, 200, 299, 399, 2, 150, 202, 0};
      tbl[6]  = '{1, 100, 200, 299, 399, 2,  99, 200, 0};
      tbl[7]  = '{1, 101, 200, 299, 399, 1, 100, 250, 0};
      tbl[8]  = '{1, 101, 200, 299, 399, 1, 101, 250, 1};
      tbl[9]  = '{1,   2,   2,  11,  11, 15,  2,   2, 1};
      tbl[10] = '{1,   2,   2,  11,  11, 15,  6,   7, 1};
      tbl[11] = '{1,   2,   2,  11,  11, 15, 11,  11, 1};
      tbl[12] = '{1,   2,   2,  11,  11, 15, 12,   5, 0};
      tbl[13] = '{1,  50,  10,  40,  20, 1,  45,  15, 0};
      tbl[14] = '{1,  50,  10,  40,  20, 1,  40,  10, 0};
      tbl[15] = '{1, 100, 200, 299, 399, 0, 100, 200, 0};
      tbl[16] = '{0, 100, 200, 299, 399, 2, 100, 200, 0};
      tbl[17] = '{1, 1000,  0, 1079, 10, 1, 1079,  5, 1};
      tbl[18] = '{1, 1000,  0, 1079, 10, 1, 1078,  5, 0};

      rst_n = 1'b0;
      in_hs = 0; in_vs = 0; in_valid = 0; in_r = '0; in_g = '0; in_b = '0;
      set_cfg(0, 0, 0, 0, 0, 0, '0);
      model_reset();
      repeat (3) @(negedge clk);
      outputs_zero("reset_state");
      drive(0, 0, 0, 1);

      // Pass-through with the box disabled: two full frames, one frame_done each.
      set_cfg(0, 0, 0, 1079, 1919, 3, 24'hFFFFFF);
      fd_count = 0;
      for (int f = 0; f < 2; f++) begin
         vs_pulse();
         for (int l = 0; l < V - 1; l++) line(1);
         line(H / 2);
         drive(0, 0, 0);
         drive(0, 0, 0);
         check("frame_done_count", 64'(fd_count), 64'(f + 1));
      end

      // Single-pixel probes; the last probe row runs past the saturation point.
      for (int i = 0; i < 19; i++) begin
         set_cfg(tbl[i].en, tbl[i].x0, tbl[i].y0, tbl[i].x1, tbl[i].y1, tbl[i].t, GREEN);
         set_probe(tbl[i].px, tbl[i].py, tbl[i].exp_col);
         p0 = probe_cnt;
         vs_pulse();
         for (int l = 0; l <= tbl[i].py; l++) line(l == tbl[i].py ? tbl[i].px / 2 + 3 : 1);
         drive(0, 0, 0);
         drive(0, 0, 0);
         check("probe_seen", 64'(probe_cnt > p0), 64'd1);
      end

      // Config change mid-frame only shows up after the next vs rise.
      set_cfg(1, 100, 200, 299, 399, 2, GREEN);
      set_probe(1, 501, 0);
      vs_pulse();
      for (int l = 0; l <= 501; l++) begin
         if (l == 500) set_cfg(1, 0, 0, 599, 599, 3, GREEN);
         line(l == 501 ? 3 : 1);
      end
      set_probe(1, 501, 1);
      p0 = probe_cnt;
      vs_pulse();
      for (int l = 0; l <= 501; l++) line(l == 501 ? 3 : 1);
      drive(0, 0, 0);
      drive(0, 0, 0);
      check("probe_seen_new_cfg", 64'(probe_cnt > p0), 64'd1);

      // Reset mid-line at x_pair 300, then realignment from the next vs rise.
      set_cfg(1, 0, 0, 1079, 1919, 15, GREEN);
      set_probe(-10, -10, 0);
      vs_pulse();
      for (int l = 0; l < 5; l++) line(1);
      drive(1, 0, 0);
      repeat (300) drive(0, 0, 1);
      @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      #1;
      outputs_zero("reset_async");
      model_reset();
      repeat (3) drive(0, 0, 0);
      outputs_zero("reset_hold");
      set_probe(4, 0, 0);
      p0 = probe_cnt;
      drive(0, 0, 0, 1);
      line(5);
      set_probe(4, 0, 1);
      vs_pulse();
      line(5);
      drive(0, 0, 0);
      drive(0, 0, 0);
      check("probe_seen_after_reset", 64'(probe_cnt - p0), 64'd2);

      repeat (4) drive(0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tinyml_display_box_overlay.md
Name: tinyml_display_box_overlay

Overview:
- Downstream stage of the DSI display pipeline. Consumes the 2-pixel-per-clock video stream (hs/vs/valid/r/g/b, 16-bit channels = two 8-bit pixels) from the display stage and drives the DSI TX video input.
- Draws one configurable rectangular bounding-box outline (detection result) over the live stream.
- Box configuration is shadowed per frame, so a mid-frame update never tears the box.

Parameters:
- H_ACTIVE, 1080, active pixels per line (even).
- V_ACTIVE, 1920, active lines per frame.
- COORD_W, 11, coordinate width in bits.

Ports:
- clk  in  1  video pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- in_hs  in  1  active-high hsync.
- in_vs  in  1  active-high vsync.
- in_valid  in  1  active data enable.
- in_r, in_g, in_b  in  16 each  two pixels per channel; [7:0] = even pixel, [15:8] = odd pixel.
- cfg_box_en  in  1  enable box drawing.
- cfg_x0, cfg_y0, cfg_x1, cfg_y1  in  COORD_W each  inclusive box corners, in pixel coordinates.
- cfg_thick  in  4  border thickness in pixels; 0 = no box.
- cfg_colour  in  24  box colour {b,g,r}, 8 bits each.
- out_hs, out_vs, out_valid  out  1 each  delayed syncs.
- out_r, out_g, out_b  out  16 each  overlaid pixels.
- frame_done  out  1  one-cycle pulse when the last active pixel pair of a frame is output.

Behaviour:
- Reset: all outputs 0; shadow registers 0, so the box is disabled until the first frame latch. Reset is asynchronous and may assert at any time; on release the block resumes from the next vs rising edge with counters at 0.
- Latency: fixed 2 cycles for every input signal to the matching output. hs, vs and valid are delayed alongside the data; the block applies no backpressure.
- Shadowing: on in_vs rising edge (in_vs=1, registered previous vs=0), all cfg_* inputs are copied into shadow registers. Drawing uses only the shadow values. cfg changes at any other time take effect on the next frame.
- Counters:
  - x_pair: increments on each in_valid cycle; cleared on in_hs rising edge and on in_vs rising edge.
  - y_line: increments on each in_valid falling edge; cleared on in_vs rising edge.
  - Both saturate at H_ACTIVE/2-1 and V_ACTIVE-1 respectively; they never wrap.
- Pixel coordinates per lane: x = 2*x_pair + lane (lane 0 = [7:0], lane 1 = [15:8]); y = y_line.
- Stage 1 (registered): compute per-lane hit flags.
  - outer = x0<=x<=x1 and y0<=y<=y1.
  - inner = x0+t<=x<=x1-t and y0+t<=y<=y1-t.
  - hit = box_en and t!=0 and outer and not inner.
  - Arithmetic: use COORD_W+1 bits so that x0+t never overflows and x1-t underflowing below 0 is treated as an empty inner rectangle (whole outer region filled).
  - Degenerate box (x1<x0 or y1<y0): hit = 0 everywhere.
  - Coordinates beyond the active area clip naturally (those pixels never occur).
- Stage 2 (registered): each lane's byte of out_r/g/b = hit ? cfg_colour byte : input byte. Lanes are independent, so a box edge may fall on an odd pixel.
- frame_done: asserted with out_valid for the pair x_pair=H_ACTIVE/2-1, y_line=V_ACTIVE-1.
- Simultaneous in_vs rise and in_valid: the vs rise takes priority (counters clear); the pixel is treated as x_pair=0, y=0.

Decomposition:
- Shared package tinyml_display_pkg: DSI_H_ACTIVE=1080, DSI_V_ACTIVE=1920, PIX_W=8, PPC=2, and the colour-triplet width constant. The display stage uses the same package.
- One sub-module: tinyml_display_box_hit — combinational per-lane hit test on (x, y, shadow cfg), instantiated twice (lane 0, lane 1). The parent registers its output.

Test Plan:
- Pass-through, cfg_box_en=0, random data -> out == in delayed by exactly 2 cycles, including hs/vs/valid; frame_done pulses once per frame.
- Box x0=100 y0=200 x1=299 y1=399 t=2, colour 24'h00FF00 -> pixels (100,200), (101,300), (299,399) and (150,201) green; (102,300) and (150,202) unchanged; (99,200) unchanged.
- Odd edge x0=101 t=1 -> pair 50 has lane 0 (x=100) original and lane 1 (x=101) coloured.
- cfg change mid-frame at y=500 -> current frame keeps the old box; next frame (after vs rise) shows the new box.
- t=15 on a 10x10 box (x1-t underflows) -> the whole 10x10 region is filled; x1<x0 -> no pixels coloured.
- rst_n asserted mid-line at x_pair=300 -> all outputs go to 0 immediately; after release, the first frame is aligned correctly from the vs rise with the box disabled until that vs latch.
